seg7_bin_display: RTL

- Parametrised multi-digit successor to the single-digit BCD-to-7-segment decoder.
- Accepts an unsigned binary value through a valid/ready handshake and converts it to NDIGITS BCD digits with a sequential double-dabble, one bit per cycle.
- Drives NDIGITS 7-segment displays, with optional leading-zero blanking and an overflow indication.
- Sits between lab datapaths (counters, ALU results) and the board HEX displays.

---
 rtl/seg7_pkg.sv | 32 +++
 rtl/seg7_digit.sv | 22 ++
 rtl/seg7_bin_display.sv | 129 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types and segment encodings for the binary-to-7-segment display path.
// Segment vectors are active-high, bit order g..a (bit 6 = g, bit 0 = a).
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    UPDATE
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] i_bcd);
    logic [6:0] r_seg;
    case (i_bcd)
      4'd0:    r_seg = 7'b0111111;
      4'd1:    r_seg = 7'b0000110;
      4'd2:    r_seg = 7'b1011011;
      4'd3:    r_seg = 7'b1001111;
      4'd4:    r_seg = 7'b1100110;
      4'd5:    r_seg = 7'b1101101;
      4'd6:    r_seg = 7'b1111101;
      4'd7:    r_seg = 7'b0000111;
      4'd8:    r_seg = 7'b1111111;
      4'd9:    r_seg = 7'b1101111;
      default: r_seg = SEG_DASH;
    endcase
    return r_seg;
  endfunction

endpackage

// File: rtl/seg7_digit.sv
// One 7-segment digit: BCD decode with dash/blank overrides and output polarity.
module seg7_digit (
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  input  logic       i_dash,
  input  logic       i_active_low,
  output logic [6:0] o_seg
);
  import seg7_pkg::*;

  logic [6:0] w_seg;

  // Dash outranks blank so an overflow is never hidden by zero blanking.
  always_comb begin
    w_seg = bcd_to_seg(i_bcd);
    if (i_blank) w_seg = SEG_BLANK;
    if (i_dash)  w_seg = SEG_DASH;
  end

  assign o_seg = i_active_low ? ~w_seg : w_seg;

endmodule

// File: rtl/seg7_bin_display.sv
// Binary value to NDIGITS 7-segment displays via sequential double-dabble,
// with valid/ready input, leading-zero blanking and overflow dashes.
module seg7_bin_display #(
  parameter int WIDTH      = 10,
  parameter int NDIGITS    = 3,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       value,
  input  logic                   blank_lz,
  output logic [NDIGITS*7-1:0]   hex,
  output logic                   done,
  output logic                   overflow
);
  import seg7_pkg::*;

  localparam int BCDW = NDIGITS * 4;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [6:0]    SEG_OFF  = (ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_bin;
  logic [BCDW-1:0]      r_bcd;
  logic [CW-1:0]        r_cnt;
  logic                 r_blank_lz;
  logic                 r_ovf_sticky;
  logic [NDIGITS*7-1:0] r_hex;
  logic                 r_done;
  logic                 r_overflow;

  logic [BCDW-1:0]      w_bcd_adj;
  logic [BCDW-1:0]      w_bcd_shift;
  logic [NDIGITS:0]     w_lead_zero;
  logic [NDIGITS*7-1:0] w_seg;

  assign in_ready = (r_state == IDLE);
  assign hex      = r_hex;
  assign done     = r_done;
  assign overflow = r_overflow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = CONVERT;
      CONVERT: if (r_cnt == LAST_BIT) w_state_next = UPDATE;
      UPDATE:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  assign w_bcd_shift = {w_bcd_adj[BCDW-2:0], r_bin[WIDTH-1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin        <= '0;
      r_bcd        <= '0;
      r_cnt        <= '0;
      r_blank_lz   <= 1'b0;
      r_ovf_sticky <= 1'b0;
      r_hex        <= {NDIGITS{SEG_OFF}};
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_bin        <= value;
            r_blank_lz   <= blank_lz;
            r_bcd        <= '0;
            r_cnt        <= '0;
            r_ovf_sticky <= 1'b0;
          end
        end
        CONVERT: begin
          r_bcd <= w_bcd_shift;
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt + 1'b1;
          // A set MSB after adjust means the top digit doubles past 9.
          if (w_bcd_adj[BCDW-1]) r_ovf_sticky <= 1'b1;
        end
        UPDATE: begin
          r_hex      <= w_seg;
          r_overflow <= r_ovf_sticky;
          r_done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // w_lead_zero[k]: digits k..NDIGITS-1 are all zero.
  assign w_lead_zero[NDIGITS] = 1'b1;

  for (genvar k = 0; k < NDIGITS; k++) begin : g_digit
    logic w_blank;
    assign w_lead_zero[k] = w_lead_zero[k+1] & (r_bcd[4*k +: 4] == 4'd0);
    if (k == 0) begin : g_lsd
      assign w_blank = 1'b0;
    end else begin : g_upper
      assign w_blank = r_blank_lz & w_lead_zero[k];
    end
    seg7_digit u_digit (
      .i_bcd        (r_bcd[4*k +: 4]),
      .i_blank      (w_blank),
      .i_dash       (r_ovf_sticky),
      .i_active_low (ACTIVE_LOW != 0),
      .o_seg        (w_seg[7*k +: 7])
    );
  end

endmodule
